shift_register_univ: RTL
========================

Name: shift_register_univ

Overview:
Parametrised universal shift register, the successor to the team's fixed 4-bit left/right shifter.
- Adds configurable width, parallel load, serial fill and serial-out.
- Five shift modes: logical left, logical right, arithmetic right, rotate left, rotate right.
- A multi-step shift command executes one bit per cycle under a start/busy/done handshake with abort.
- Used as a datapath utility and serializer in lab-level designs.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- RST_VAL, 8'b1010_1010, value of out after reset (WIDTH bits).
- CNT_W, $clog2(WIDTH+1), width of shift_amt and the internal step counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_en  in  1  parallel load request; honoured only in IDLE.
- load_data  in  WIDTH  parallel load value.
- start  in  1  shift command request; honoured only in IDLE.
- mode  in  3  000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR; 101-111 reserved (hold).
- shift_amt  in  CNT_W  number of single-bit steps, 0..2^CNT_W-1.
- serial_in  in  1  fill bit for LSL (into bit 0) and LSR (into bit WIDTH-1); sampled on every step.
- abort  in  1  cancels an in-progress command.
- out  out  WIDTH  register contents.
- serial_out  out  1  bit most recently shifted or rotated out.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse on command completion.

Behaviour:
Reset (async, any state):
- out=RST_VAL, serial_out=0, busy=0, done=0, state=IDLE, counter=0.

States: IDLE, SHIFT, DONE.

IDLE:
- load_en=1: out<=load_data, serial_out<=0; stay in IDLE.
- Else start=1: latch mode and shift_amt.
  - shift_amt=0: go to DONE; out unchanged.
  - shift_amt>0: go to SHIFT, counter<=shift_amt.
- load_en and start together: load wins, start is dropped (not queued).

SHIFT:
- Each edge performs one step on out and decrements the counter.
- Edge with counter==1 performs the final step and goes to DONE.
- Latched mode is used throughout; changes to the mode and shift_amt inputs are ignored.
- serial_in is sampled live on each step.
- abort=1 has priority over the step on that edge: out holds its current value, go to IDLE, no done pulse.
- load_en and start are ignored.

DONE:
- done=1 for exactly one cycle, then IDLE.
- start, load_en and abort are ignored.

Step definitions (per single step; s = serial_out update):
- LSL: {out[W-2:0],serial_in}, s=out[W-1].
- LSR: {serial_in,out[W-1:1]}, s=out[0].
- ASR: {out[W-1],out[W-1:1]}, s=out[0].
- ROL: {out[W-2:0],out[W-1]}, s=out[W-1].
- ROR: {out[0],out[W-1:1]}, s=out[0].
- Reserved modes: out and serial_out unchanged; the counter still runs and done still pulses.

Timing and other rules:
- Latency: start accepted at edge E; out is final at edge E+N; done is high in the cycle after edge E+N.
- busy is high for exactly N cycles; for N=0, busy is never high.
- Amounts >= WIDTH are not clamped: rotates wrap naturally, and logical shifts fully flush to the fill bits.
- abort outside SHIFT has no effect.

Decomposition:
- Package shift_univ_pkg holds:
  - mode encodings: MODE_LSL, MODE_LSR, MODE_ASR, MODE_ROL, MODE_ROR.
  - state encodings: ST_IDLE, ST_SHIFT, ST_DONE.
- Sub-module shift_univ_step: purely combinational, WIDTH-parametrised.
  - Inputs: value, mode, serial_in.
  - Outputs: next value and the shifted-out bit.
- The top level holds the FSM, counter and registers.

Test Plan (WIDTH=8):
- Reset: assert rst mid-cycle -> out=0xAA, busy=0, done=0, serial_out=0 immediately, without waiting for a clock edge.
- LSL from reset, shift_amt=3, serial_in=1 -> out steps 0x55, 0xAB, 0x57; busy high 3 cycles; final serial_out=1; done pulses once in the 4th cycle after start.
- Load 0x90, then ASR shift_amt=2 -> 0xC8, 0xE4; serial_out=0. Separately, load_en and start in the same cycle -> loaded value present, start dropped, no busy.
- Load 0x81, ROR shift_amt=9 -> out=0x81 after 8 steps, 0xC0 after 9; serial_out=1; busy high 9 cycles. Separately, shift_amt=0 -> done the next cycle, out unchanged, busy never high.
- Load 0xF0, LSR shift_amt=4 with serial_in=0, abort after 2 steps -> out=0x3C, back in IDLE, no done pulse; a following start is accepted normally.
- rst asserted during SHIFT -> out=0xAA and IDLE asynchronously; no done pulse after rst is released.

Source files
------------

// File: rtl/shift_univ_pkg.sv
// -----------------------------------------------------------------------------
// shift_univ_pkg
// Shared encodings for the universal shift register.
//   MODE_*  : 3-bit shift mode codes. Codes 101..111 are reserved. A reserved
//             code leaves the register contents unchanged.
//   state_e : control FSM states of the top level.
// -----------------------------------------------------------------------------
package shift_univ_pkg;

   localparam logic [2:0] MODE_LSL = 3'b000;
   localparam logic [2:0] MODE_LSR = 3'b001;
   localparam logic [2:0] MODE_ASR = 3'b010;
   localparam logic [2:0] MODE_ROL = 3'b011;
   localparam logic [2:0] MODE_ROR = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage : shift_univ_pkg

// File: rtl/shift_univ_step.sv
// -----------------------------------------------------------------------------
// shift_univ_step
// Combinational single-bit step of the universal shifter.
// Ports:
//   value_i     : current register value (WIDTH bits)
//   mode_i      : shift mode (see shift_univ_pkg)
//   serial_in_i : fill bit for the logical shifts
//   value_o     : value after one step
//   shift_out_o : bit shifted or rotated out by this step
//   shift_vld_o : high when mode_i is a defined mode. When it is low, the
//                 caller keeps its serial-out bit unchanged.
// -----------------------------------------------------------------------------
module shift_univ_step
   import shift_univ_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] value_i,
   input  logic [2:0]       mode_i,
   input  logic             serial_in_i,
   output logic [WIDTH-1:0] value_o,
   output logic             shift_out_o,
   output logic             shift_vld_o
);

   always_comb begin
      value_o     = value_i;
      shift_out_o = 1'b0;
      shift_vld_o = 1'b0;
      case (mode_i)
         MODE_LSL: begin
            value_o     = {value_i[WIDTH-2:0], serial_in_i};
            shift_out_o = value_i[WIDTH-1];
            shift_vld_o = 1'b1;
         end
         MODE_LSR: begin
            value_o     = {serial_in_i, value_i[WIDTH-1:1]};
            shift_out_o = value_i[0];
            shift_vld_o = 1'b1;
         end
         MODE_ASR: begin
            value_o     = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
            shift_out_o = value_i[0];
            shift_vld_o = 1'b1;
         end
         MODE_ROL: begin
            value_o     = {value_i[WIDTH-2:0], value_i[WIDTH-1]};
            shift_out_o = value_i[WIDTH-1];
            shift_vld_o = 1'b1;
         end
         MODE_ROR: begin
            value_o     = {value_i[0], value_i[WIDTH-1:1]};
            shift_out_o = value_i[0];
            shift_vld_o = 1'b1;
         end
         default: begin
            value_o     = value_i;
            shift_out_o = 1'b0;
            shift_vld_o = 1'b0;
         end
      endcase
   end

endmodule : shift_univ_step

// File: rtl/shift_register_univ.sv
// -----------------------------------------------------------------------------
// shift_register_univ
// Parametrised universal shift register. It supports parallel load and a
// multi-step shift command. The command runs one bit per cycle under a
// start/busy/done handshake, and abort cancels it.
// Ports:
//   clk, rst   : clock and asynchronous active-high reset
//   load_en    : parallel load request (IDLE only), data on load_data
//   start      : shift command request (IDLE only)
//   mode       : shift mode, latched at start
//   shift_amt  : number of single-bit steps, latched at start
//   serial_in  : fill bit for LSL/LSR, sampled live on every step
//   abort      : cancels a command in progress (no done pulse)
//   out        : register contents
//   serial_out : bit most recently shifted or rotated out
//   busy       : high while stepping
//   done       : one-cycle completion pulse
// -----------------------------------------------------------------------------
module shift_register_univ
   import shift_univ_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = 8'b1010_1010,
   parameter int               CNT_W   = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_data,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [CNT_W-1:0] shift_amt,
   input  logic             serial_in,
   input  logic             abort,
   output logic [WIDTH-1:0] out,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       mode_q;
   logic [WIDTH-1:0] out_q;
   logic             sout_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH-1:0] out_d;
   logic             sout_d;
   logic             sout_vld;

   // The step uses the latched mode, so changes on the mode input during a
   // command have no effect.
   shift_univ_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .value_i     (out_q),
      .mode_i      (mode_q),
      .serial_in_i (serial_in),
      .value_o     (out_d),
      .shift_out_o (sout_d),
      .shift_vld_o (sout_vld)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= CNT_ZERO;
         mode_q  <= MODE_LSL;
         out_q   <= RST_VAL;
         sout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               // Load has priority. A start in the same cycle is dropped.
               if (load_en) begin
                  out_q  <= load_data;
                  sout_q <= 1'b0;
               end else if (start) begin
                  mode_q <= mode;
                  if (shift_amt == CNT_ZERO) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_SHIFT;
                     cnt_q   <= shift_amt;
                     busy_q  <= 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= CNT_ZERO;
                  busy_q  <= 1'b0;
               end else begin
                  out_q <= out_d;
                  if (sout_vld) begin
                     sout_q <= sout_d;
                  end
                  cnt_q <= cnt_q - CNT_ONE;
                  if (cnt_q == CNT_ONE) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign out        = out_q;
   assign serial_out = sout_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule : shift_register_univ
